dsp_mac_chan: RTL

DSP_MAC_CHAN -- requirements
Module: dsp_mac_chan

---
 rtl/dsp_mac_chan_if.sv | 37 +++
 rtl/dsp_mac_chan.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_chan_if.sv
// Handshake and data bundle for the dsp_mac_chan multiply-accumulate channel.
// The master side offers beats and consumes results; the slave side is the MAC.
interface dsp_mac_chan_if #(
    parameter int AW  = 18,
    parameter int BW  = 18,
    parameter int PW  = 48,
    parameter int NCH = 4
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    // Input beat
    logic                 IN_VALID;
    logic                 IN_READY;
    logic signed [AW-1:0] A;
    logic signed [BW-1:0] B;
    logic signed [BW-1:0] D;
    logic [CW-1:0]        CH;
    logic [2:0]           MODE;
    logic                 LAST;

    // Result
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic signed [PW-1:0] P;
    logic [CW-1:0]        P_CH;
    logic                 OVF;

    modport master (
        output IN_VALID, A, B, D, CH, MODE, LAST, OUT_READY,
        input  IN_READY, OUT_VALID, P, P_CH, OVF
    );

    modport slave (
        input  IN_VALID, A, B, D, CH, MODE, LAST, OUT_READY,
        output IN_READY, OUT_VALID, P, P_CH, OVF
    );
endinterface

// File: rtl/dsp_mac_chan.sv
// Multi-channel pre-add / multiply / accumulate pipeline.
// S1 registers the beat, S2 the pre-adder, S3 the product, and S4 updates the
// channel accumulator and loads the result register on LAST beats. A single
// stall (result pending and not taken) freezes every stage.
module dsp_mac_chan #(
    parameter int AW  = 18,
    parameter int BW  = 18,
    parameter int PW  = 48,
    parameter int NCH = 4,
    parameter int SAT = 1
) (
    input logic           CLK,
    input logic           RST,
    dsp_mac_chan_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int XW = BW + 1;        // pre-adder width
    localparam int MW = AW + BW + 1;   // full product width

    localparam logic signed [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};

    // Flow control
    logic stall;
    logic accept;

    // Stage 1: registered beat
    logic                 s1_vld_q;
    logic signed [AW-1:0] s1_a_q;
    logic signed [BW-1:0] s1_b_q;
    logic signed [BW-1:0] s1_d_q;
    logic [CW-1:0]        s1_ch_q;
    logic [2:0]           s1_mode_q;
    logic                 s1_last_q;

    // Stage 2: pre-adder result
    logic                 s2_vld_q;
    logic signed [AW-1:0] s2_a_q;
    logic signed [XW-1:0] s2_pre_q;
    logic [CW-1:0]        s2_ch_q;
    logic                 s2_clr_q;
    logic                 s2_last_q;

    // Stage 3: product
    logic                 s3_vld_q;
    logic signed [MW-1:0] s3_prod_q;
    logic [CW-1:0]        s3_ch_q;
    logic                 s3_clr_q;
    logic                 s3_last_q;

    // Channel state
    logic signed [PW-1:0] acc_q [NCH];
    logic [NCH-1:0]       sticky_q;

    // Result register
    logic                 out_valid_q;
    logic signed [PW-1:0] p_q;
    logic [CW-1:0]        p_ch_q;
    logic                 ovf_q;

    // Combinational datapath
    logic signed [XW-1:0] b_ext;
    logic signed [XW-1:0] d_ext;
    logic signed [XW-1:0] pre_d;
    logic signed [MW-1:0] prod_d;
    logic signed [PW-1:0] prod_ext;
    logic signed [PW-1:0] acc_cur;
    logic                 sticky_cur;
    logic signed [PW-1:0] acc_base;
    logic signed [PW-1:0] sum_raw;
    logic                 ovf;
    logic signed [PW-1:0] acc_d;
    logic                 sticky_d;
    logic                 in_range;
    logic                 acc_we;
    logic                 load_out;

    assign stall        = out_valid_q && !bus.OUT_READY;
    assign accept       = bus.IN_VALID && !stall;
    assign bus.IN_READY = !stall;

    assign bus.OUT_VALID = out_valid_q;
    assign bus.P         = p_q;
    assign bus.P_CH      = p_ch_q;
    assign bus.OVF       = ovf_q;

    // Stage valid bits advance together whenever the pipeline is not stalled
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
        end else if (!stall) begin
            s1_vld_q <= accept;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
        end
    end

    // Stage data registers, loaded only behind a valid beat
    // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (accept) begin
            s1_a_q    <= bus.A;
            s1_b_q    <= bus.B;
            s1_d_q    <= bus.D;
            s1_ch_q   <= bus.CH;
            s1_mode_q <= bus.MODE;
            s1_last_q <= bus.LAST;
        end
        if (!stall && s1_vld_q) begin
            s2_a_q    <= s1_a_q;
            s2_pre_q  <= pre_d;
            s2_ch_q   <= s1_ch_q;
            s2_clr_q  <= s1_mode_q[2];
            s2_last_q <= s1_last_q;
        end
        if (!stall && s2_vld_q) begin
            s3_prod_q <= prod_d;
            s3_ch_q   <= s2_ch_q;
            s3_clr_q  <= s2_clr_q;
            s3_last_q <= s2_last_q;
        end
    end

    assign b_ext = XW'(s1_b_q);
    assign d_ext = XW'(s1_d_q);

    // Pre-adder at BW+1 bits so D+/-B never wraps
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        pre_d = b_ext;
        if (s1_mode_q[0]) begin
            pre_d = s1_mode_q[1] ? (d_ext - b_ext) : (d_ext + b_ext);
        end
    end

    assign prod_d   = MW'(s2_a_q) * MW'(s2_pre_q);
    assign prod_ext = PW'(s3_prod_q);
    assign in_range = int'(s3_ch_q) < NCH;
    assign acc_we   = s3_vld_q && in_range && !stall;
    assign load_out = acc_we && s3_last_q;

    // Select the addressed channel's accumulator and sticky flag
    always_comb begin
        acc_cur    = '0;
        sticky_cur = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(s3_ch_q) == i) begin
                acc_cur    = acc_q[i];
                sticky_cur = sticky_q[i];
            end
        end
    end

    // Accumulate with signed-overflow detection and optional clamping
    always_comb begin
        acc_base = s3_clr_q ? '0 : acc_cur;
        sum_raw  = acc_base + prod_ext;
        ovf      = (acc_base[PW-1] == prod_ext[PW-1]) && (sum_raw[PW-1] != acc_base[PW-1]);
        acc_d    = sum_raw;
        if (SAT != 0 && ovf) begin
            acc_d = acc_base[PW-1] ? P_MIN : P_MAX;
        end
        sticky_d = sticky_cur | ovf;
    end

    // Channel accumulators: update on every in-range beat, clear after LAST
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
            end
            sticky_q <= '0;
        end else if (acc_we) begin
            for (int i = 0; i < NCH; i++) begin
                if (int'(s3_ch_q) == i) begin
                    acc_q[i]    <= s3_last_q ? '0 : acc_d;
                    sticky_q[i] <= s3_last_q ? 1'b0 : sticky_d;
                end
            end
        end
    end

    // Result register: new LAST result wins over draining the old one
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
            p_ch_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= load_out;
            if (load_out) begin
                p_q    <= acc_d;
                p_ch_q <= s3_ch_q;
                ovf_q  <= sticky_d;
            end
        end
    end
endmodule
